// File: rtl/pipeline_pkg.sv
// Shared types and widths for the 16-bit 5-stage pipeline.
package pipeline_pkg;

  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned ALUOP_W    = 2;

  typedef enum logic {
    IDLE,
    STALL
  } hazardState_t;

endpackage

// File: rtl/hazard_stats_counter.sv
// 16-bit saturating event counter with enable and synchronous clear.
module hazard_stats_counter
  import pipeline_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic              enable,
  output logic [DATA_W-1:0] count
);

  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + DATA_W'(1);
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use stall and taken-branch flush controller for the 5-stage pipeline.
// Optional cumulative stall/flush statistics are built when HAZARD_STATS_EN is defined.
module hazard_control_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned STALL_CYCLES       = 1,
  parameter bit          REG_ZERO_HARDWIRED = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_rt,
  input  logic                  branch_taken,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  exmem_flush,
  output logic                  stall_active,
  output logic [DATA_W-1:0]     stall_count,
  output logic [DATA_W-1:0]     flush_count
);

  // cnt holds the stall cycles still owed after the current one, minus one,
  // so the first (IDLE) stall cycle plus cnt+1 STALL cycles totals STALL_CYCLES.
  localparam logic [2:0] STALL_RELOAD = (STALL_CYCLES > 1) ? 3'(STALL_CYCLES - 2) : 3'd0;

  hazardState_t state, stateNext;
  logic [2:0]   cnt, cntNext;
  logic         rsMatch, rtMatch, zeroSkip, hazard;

  always_comb begin
    rsMatch  = (idex_rt == id_rs);
    rtMatch  = id_uses_rt && (idex_rt == id_rt);
    zeroSkip = REG_ZERO_HARDWIRED && (idex_rt == '0);
    hazard   = idex_mem_read && (rsMatch || rtMatch) && !zeroSkip;
  end

  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_flush  = 1'b0;
    stall_active = 1'b0;

    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
      stateNext   = IDLE;
      cntNext     = '0;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
      stateNext   = IDLE;
      cntNext     = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hazard) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_bubble  = 1'b1;
            stall_active = 1'b1;
            if (STALL_CYCLES > 1) begin
              stateNext = STALL;
              cntNext   = STALL_RELOAD;
            end
          end
        end
        STALL: begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_bubble  = 1'b1;
          stall_active = 1'b1;
          if (cnt == '0) begin
            stateNext = IDLE;
          end else begin
            cntNext = cnt - 3'd1;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

`ifdef HAZARD_STATS_EN
  hazard_stats_counter stallCounter (
    .clock  (clock),
    .clear  (reset),
    .enable (stall_active),
    .count  (stall_count)
  );

  hazard_stats_counter flushCounter (
    .clock  (clock),
    .clear  (reset),
    .enable (branch_taken && !reset),
    .count  (flush_count)
  );
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: two instances (1-cycle/zero-hardwired and 3-cycle/no-zero) on shared inputs.
module tb_hazard_control_unit;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, stall_active}
  localparam logic [5:0] NORM = 6'b110000;
  localparam logic [5:0] STL  = 6'b000101;
  localparam logic [5:0] BR   = 6'b111110;
  localparam logic [5:0] RST  = 6'b001110;

  typedef struct packed {
    logic       rst;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       usesRt;
    logic       memRead;
    logic [2:0] exRt;
    logic       br;
    logic [5:0] expA;
  } vec_t;

  typedef struct packed {
    logic [5:0]  ctl;
    logic [15:0] sc;
    logic [15:0] fc;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  id_rs = '0, id_rt = '0, idex_rt = '0;
  logic        id_uses_rt = 1'b0, idex_mem_read = 1'b0, branch_taken = 1'b0;
  logic [5:0]  ctlA, ctlB;
  logic [15:0] scA, fcA, scB, fcB;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned stepNo = 0;
  int          remB = 0;
  int unsigned scMA = 0, fcMA = 0, scMB = 0, fcMB = 0;
  exp_t        sb[$];
  vec_t        vecs[18];

  always #5 clock = ~clock;

  hazard_control_unit #(.STALL_CYCLES(1), .REG_ZERO_HARDWIRED(1'b1)) dutA (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .branch_taken(branch_taken),
    .pc_write(ctlA[5]), .ifid_write(ctlA[4]), .ifid_flush(ctlA[3]), .idex_bubble(ctlA[2]),
    .exmem_flush(ctlA[1]), .stall_active(ctlA[0]), .stall_count(scA), .flush_count(fcA)
  );

  hazard_control_unit #(.STALL_CYCLES(3), .REG_ZERO_HARDWIRED(1'b0)) dutB (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .branch_taken(branch_taken),
    .pc_write(ctlB[5]), .ifid_write(ctlB[4]), .ifid_flush(ctlB[3]), .idex_bubble(ctlB[2]),
    .exmem_flush(ctlB[1]), .stall_active(ctlB[0]), .stall_count(scB), .flush_count(fcB)
  );

  function automatic vec_t mk(input logic rst, input logic [2:0] rs, input logic [2:0] rt,
                              input logic usesRt, input logic memRead, input logic [2:0] exRt,
                              input logic br, input logic [5:0] expA);
    vec_t v;
    v.rst = rst; v.rs = rs; v.rt = rt; v.usesRt = usesRt; v.memRead = memRead;
    v.exRt = exRt; v.br = br; v.expA = expA;
    return v;
  endfunction

  function automatic logic hazardOf(input vec_t v, input logic zeroHardwired);
    logic hit;
    hit = v.memRead && ((v.exRt == v.rs) || (v.usesRt && (v.exRt == v.rt)));
    if (zeroHardwired && (v.exRt == 3'd0)) hit = 1'b0;
    return hit;
  endfunction

  function automatic logic [15:0] cntView(input int unsigned n);
`ifdef HAZARD_STATS_EN
    return 16'(n);
`else
    return (n == 0) ? 16'h0000 : 16'h0000;
`endif
  endfunction

  function automatic int unsigned satInc(input int unsigned n, input logic en);
    return (en && n < 32'd65535) ? n + 1 : n;
  endfunction

  task automatic compareObs(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got ctl=%b sc=%h fc=%h, expected ctl=%b sc=%h fc=%h",
               name, stepNo, act.ctl, act.sc, act.fc, exp.ctl, exp.sc, exp.fc);
    end
  endtask

  task automatic applyVec(input vec_t v);
    exp_t       e, got;
    logic [5:0] cB;
    int         remNext;
    @(posedge clock);
    #1;
    reset         = v.rst;
    id_rs         = v.rs;
    id_rt         = v.rt;
    id_uses_rt    = v.usesRt;
    idex_mem_read = v.memRead;
    idex_rt       = v.exRt;
    branch_taken  = v.br;

    // Model for the 3-cycle instance: remB = stall cycles still owed after this one.
    if (v.rst) begin
      cB = RST; remNext = 0;
    end else if (v.br) begin
      cB = BR; remNext = 0;
    end else if (remB > 0) begin
      cB = STL; remNext = remB - 1;
    end else if (hazardOf(v, 1'b0)) begin
      cB = STL; remNext = 2;
    end else begin
      cB = NORM; remNext = 0;
    end
    e.a = {v.expA, cntView(scMA), cntView(fcMA)};
    e.b = {cB, cntView(scMB), cntView(fcMB)};
    sb.push_back(e);

    @(negedge clock);
    stepNo++;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard step %0d: got empty queue, expected one entry", stepNo);
    end else begin
      e = sb.pop_front();
      got.a = {ctlA, scA, fcA};
      got.b = {ctlB, scB, fcB};
      compareObs("dutA", got.a, e.a);
      compareObs("dutB", got.b, e.b);
    end

    remB = remNext;
    if (v.rst) begin
      scMA = 0; fcMA = 0; scMB = 0; fcMB = 0;
    end else begin
      scMA = satInc(scMA, v.expA[0]);
      scMB = satInc(scMB, cB[0]);
      fcMA = satInc(fcMA, v.br);
      fcMB = satInc(fcMB, v.br);
    end
  endtask

  initial begin
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, RST);
    vecs[1]  = mk(1, 3, 3, 1, 1, 3, 0, RST);
    vecs[2]  = mk(0, 1, 2, 1, 0, 1, 0, NORM);
    vecs[3]  = mk(0, 3, 1, 0, 1, 3, 0, STL);   // load-use on rs
    vecs[4]  = mk(0, 3, 1, 0, 0, 3, 0, NORM);
    vecs[5]  = mk(0, 2, 4, 1, 0, 6, 0, NORM);
    vecs[6]  = mk(0, 2, 4, 1, 0, 6, 0, NORM);
    vecs[7]  = mk(0, 1, 5, 1, 1, 5, 0, STL);   // load-use on rt
    vecs[8]  = mk(0, 1, 5, 1, 1, 5, 0, STL);
    vecs[9]  = mk(0, 1, 5, 1, 1, 5, 0, STL);
    vecs[10] = mk(0, 1, 5, 1, 0, 5, 0, NORM);
    vecs[11] = mk(0, 1, 5, 0, 1, 5, 0, NORM);  // rt not read: no hazard
    vecs[12] = mk(0, 0, 2, 0, 1, 0, 0, NORM);  // register zero
    vecs[13] = mk(0, 0, 2, 0, 0, 0, 0, NORM);
    vecs[14] = mk(0, 0, 2, 0, 0, 0, 0, NORM);
    vecs[15] = mk(0, 0, 2, 0, 0, 0, 0, NORM);
    vecs[16] = mk(0, 6, 7, 1, 0, 2, 1, BR);
    vecs[17] = mk(0, 6, 7, 1, 0, 2, 0, NORM);

    for (int unsigned i = 0; i < 18; i++) applyVec(vecs[i]);

    // Branch in the second stall cycle of the 3-cycle instance, hazard still asserted.
    applyVec(mk(0, 4, 1, 0, 1, 4, 0, STL));
    applyVec(mk(0, 4, 1, 0, 1, 4, 1, BR));
    applyVec(mk(0, 4, 1, 0, 0, 4, 0, NORM));
    applyVec(mk(0, 4, 1, 0, 0, 4, 0, NORM));

    // Reset mid-stall, then release with no hazard.
    applyVec(mk(0, 2, 1, 0, 1, 2, 0, STL));
    applyVec(mk(0, 2, 1, 0, 1, 2, 0, STL));
    applyVec(mk(1, 2, 1, 0, 1, 2, 0, RST));
    applyVec(mk(0, 2, 1, 0, 0, 2, 0, NORM));
    applyVec(mk(0, 2, 1, 0, 0, 2, 0, NORM));

    // Held hazard: fresh stall starts right after the previous one ends.
    for (int unsigned i = 0; i < 7; i++) applyVec(mk(0, 6, 0, 0, 1, 6, 0, STL));
    applyVec(mk(0, 6, 0, 0, 0, 6, 0, NORM));
    applyVec(mk(0, 6, 0, 0, 0, 6, 0, NORM));
    applyVec(mk(0, 6, 0, 0, 0, 6, 0, NORM));

    // Counter exercise: three single-cycle stalls and two branches after a reset.
    applyVec(mk(1, 0, 0, 0, 0, 0, 0, RST));
    for (int unsigned i = 0; i < 3; i++) begin
      applyVec(mk(0, 5, 0, 0, 1, 5, 0, STL));
      applyVec(mk(0, 5, 0, 0, 0, 5, 0, NORM));
      applyVec(mk(0, 5, 0, 0, 0, 5, 0, NORM));
      applyVec(mk(0, 5, 0, 0, 0, 5, 0, NORM));
    end
    applyVec(mk(0, 1, 0, 0, 0, 2, 1, BR));
    applyVec(mk(0, 1, 0, 0, 0, 2, 0, NORM));
    applyVec(mk(0, 1, 0, 0, 0, 2, 1, BR));
    applyVec(mk(0, 1, 0, 0, 0, 2, 0, NORM));

`ifdef HAZARD_STATS_EN
    checks++;
    if (scA !== 16'd3 || fcA !== 16'd2) begin
      errors++;
      $display("FAIL statsTotals: got stall=%0d flush=%0d, expected stall=3 flush=2", scA, fcA);
    end
    for (int unsigned i = 0; i < 70000; i++) applyVec(mk(0, 3, 0, 0, 1, 3, 0, STL));
    checks++;
    if (scA !== 16'hFFFF) begin
      errors++;
      $display("FAIL statsSaturate: got stall=%h, expected ffff", scA);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
